// File: rtl/ee354_gcd_pkg.sv
// Shared types and constants for the GCD engine scheduler.
package ee354_gcd_pkg;

  // Operand/result width; must match the GCD engine.
  localparam int unsigned W = 8;

  // One-hot state encoding.
  localparam int unsigned N_STATE = 5;
  localparam logic [N_STATE-1:0] IDLE = 5'b00001;
  localparam logic [N_STATE-1:0] LOAD = 5'b00010;
  localparam logic [N_STATE-1:0] RUN  = 5'b00100;
  localparam logic [N_STATE-1:0] ACK  = 5'b01000;
  localparam logic [N_STATE-1:0] RESP = 5'b10000;

  // Bit positions of each state in the one-hot vector.
  localparam int unsigned BIT_IDLE = 0;
  localparam int unsigned BIT_LOAD = 1;
  localparam int unsigned BIT_RUN  = 2;
  localparam int unsigned BIT_ACK  = 3;
  localparam int unsigned BIT_RESP = 4;

  typedef enum logic [N_STATE-1:0] {
    S_IDLE = IDLE,
    S_LOAD = LOAD,
    S_RUN  = RUN,
    S_ACK  = ACK,
    S_RESP = RESP
  } state_e;

  // Operand pair handed to the engine.
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } operands_t;

  // The engine never terminates on a zero operand, so those pairs are answered locally.
  function automatic logic needs_bypass(input operands_t op);
    return (op.a == '0) || (op.b == '0);
  endfunction

  // gcd(0,x) = x and gcd(0,0) = 0 both reduce to a bitwise OR when one side is zero.
  function automatic logic [W-1:0] bypass_gcd(input operands_t op);
    return op.a | op.b;
  endfunction

endpackage

// File: rtl/ee354_gcd_sched_if.sv
// Requester and engine signal bundle of the GCD scheduler.
interface ee354_gcd_sched_if
  import ee354_gcd_pkg::*;
#(
  parameter int unsigned N_REQ = 4
);

  // Requester side
  logic [N_REQ-1:0]   Req;
  logic [N_REQ*W-1:0] ReqA;
  logic [N_REQ*W-1:0] ReqB;
  logic [N_REQ-1:0]   Grant;
  logic [N_REQ-1:0]   Rsp_Valid;
  logic [W-1:0]       Rsp_Data;
  logic [N_REQ-1:0]   Rsp_Ack;

  // Engine side
  logic [W-1:0]       Eng_Ain;
  logic [W-1:0]       Eng_Bin;
  logic               Eng_Start;
  logic               Eng_Ack;
  logic               Eng_Done;
  logic [W-1:0]       Eng_Result;

  // Status
  logic               Busy;
  logic               q_Idle;
  logic               q_Load;
  logic               q_Run;
  logic               q_Ack;
  logic               q_Resp;

  // Scheduler view
  modport slave (
    input  Req, ReqA, ReqB, Rsp_Ack, Eng_Done, Eng_Result,
    output Grant, Rsp_Valid, Rsp_Data, Eng_Ain, Eng_Bin, Eng_Start, Eng_Ack,
    output Busy, q_Idle, q_Load, q_Run, q_Ack, q_Resp
  );

  // Requesters plus engine view
  modport master (
    output Req, ReqA, ReqB, Rsp_Ack, Eng_Done, Eng_Result,
    input  Grant, Rsp_Valid, Rsp_Data, Eng_Ain, Eng_Bin, Eng_Start, Eng_Ack,
    input  Busy, q_Idle, q_Load, q_Run, q_Ack, q_Resp
  );

endinterface

// File: rtl/ee354_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module ee354_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic             found_c;
  logic [IDX_W:0]   pos_c;

  // Scan from ptr upward, wrapping at N_REQ, and keep the first hit.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found_c = 1'b0;
    pos_c   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos_c = {1'b0, ptr} + (IDX_W+1)'(k);
      if (pos_c >= (IDX_W+1)'(N_REQ)) begin
        pos_c = pos_c - (IDX_W+1)'(N_REQ);
      end
      if (!found_c && req[pos_c[IDX_W-1:0]]) begin
        found_c                 = 1'b1;
        gnt[pos_c[IDX_W-1:0]]   = 1'b1;
        gnt_idx                 = pos_c[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ee354_gcd_sched.sv
// Round-robin scheduler sharing one GCD engine among N_REQ requesters.
module ee354_gcd_sched
  import ee354_gcd_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  ee354_gcd_sched_if.slave  bus
);

  localparam int unsigned IDX_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [W-1:0]       rsp_data_q, rsp_data_d;
  operands_t          opr_q, opr_d;
  logic               start_q, start_d;
  logic               eng_ack_q, eng_ack_d;
  logic               busy_q, busy_d;

  logic [N_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic [IDX_W-1:0]   ptr_inc_c;
  operands_t          sel_opr_c;

  ee354_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (bus.Req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Operand mux for the requester the arbiter picked.
  always_comb begin
    sel_opr_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_opr_c.a = bus.ReqA[i*W +: W];
        sel_opr_c.b = bus.ReqB[i*W +: W];
      end
    end
  end

  // Pointer moves one past the winner so it has lowest priority next round.
  always_comb begin
    ptr_inc_c = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    opr_d       = opr_q;
    start_d     = 1'b0;
    eng_ack_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (|bus.Req) begin
          grant_d = arb_gnt;
          opr_d   = sel_opr_c;
          ptr_d   = ptr_inc_c;
          if (needs_bypass(sel_opr_c)) begin
            rsp_data_d  = bypass_gcd(sel_opr_c);
            rsp_valid_d = arb_gnt;
            state_d     = S_RESP;
          end else begin
            start_d = 1'b1;
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        state_d = S_RUN;
      end

      S_RUN: begin
        if (bus.Eng_Done) begin
          rsp_data_d = bus.Eng_Result;
          eng_ack_d  = 1'b1;
          state_d    = S_ACK;
        end
      end

      S_ACK: begin
        rsp_valid_d = grant_q;
        state_d     = S_RESP;
      end

      S_RESP: begin
        if (|(bus.Rsp_Ack & grant_q)) begin
          grant_d     = '0;
          rsp_valid_d = '0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        grant_d     = '0;
        rsp_valid_d = '0;
        rsp_data_d  = '0;
        opr_d       = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      opr_q       <= '0;
      start_q     <= 1'b0;
      eng_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      opr_q       <= opr_d;
      start_q     <= start_d;
      eng_ack_q   <= eng_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.Grant     = grant_q;
  assign bus.Rsp_Valid = rsp_valid_q;
  assign bus.Rsp_Data  = rsp_data_q;
  assign bus.Eng_Ain   = opr_q.a;
  assign bus.Eng_Bin   = opr_q.b;
  assign bus.Eng_Start = start_q;
  assign bus.Eng_Ack   = eng_ack_q;
  assign bus.Busy      = busy_q;
  assign bus.q_Idle    = state_q[BIT_IDLE];
  assign bus.q_Load    = state_q[BIT_LOAD];
  assign bus.q_Run     = state_q[BIT_RUN];
  assign bus.q_Ack     = state_q[BIT_ACK];
  assign bus.q_Resp    = state_q[BIT_RESP];

endmodule

// File: tb/tb_ee354_gcd_sched.sv
// Scoreboard bench for ee354_gcd_sched with a behavioural GCD engine and requesters.
module tb_ee354_gcd_sched;
  import ee354_gcd_pkg::*;

  localparam int unsigned N_REQ = 4;

  logic Clk = 1'b0;
  logic Reset;

  ee354_gcd_sched_if #(.N_REQ(N_REQ)) bus ();

  ee354_gcd_sched #(.N_REQ(N_REQ)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int unsigned a;
    int unsigned b;
    int unsigned gap;
    int unsigned ackd;
  } tx_t;

  tx_t          tx_q [N_REQ][$];
  logic [W-1:0] exp_q[N_REQ][$];
  int           st   [N_REQ];
  int           ackc [N_REQ];
  logic [W-1:0] cur_a[N_REQ];
  logic [W-1:0] cur_b[N_REQ];
  int           eng_lat_fix;
  int           errors;
  int           checks;

  function automatic void chk(input string name, input int unsigned act, input int unsigned expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endfunction

  // Euclid on plain integers.
  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned x, y, t;
    x = a;
    y = b;
    if (x == 0) return W'(y);
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return W'(x);
  endfunction

  // First requester at or after ptr, wrapping; -1 if none.
  function automatic int rr_pick(input logic [N_REQ-1:0] req, input int ptr);
    int j;
    for (int k = 0; k < int'(N_REQ); k++) begin
      j = (ptr + k) % int'(N_REQ);
      if (req[j]) return j;
    end
    return -1;
  endfunction

  // ---------------- engine model ----------------
  logic [W-1:0] e_a, e_b;
  int           e_cnt;
  bit           e_busy;

  initial begin
    bus.Eng_Done   = 1'b0;
    bus.Eng_Result = '0;
    e_busy = 1'b0;
    e_cnt  = 0;
    forever begin
      @(posedge Clk or posedge Reset);
      #1;
      if (Reset) begin
        bus.Eng_Done = 1'b0;
        e_busy       = 1'b0;
      end else if (bus.Eng_Ack) begin
        bus.Eng_Done = 1'b0;
        e_busy       = 1'b0;
      end else if (bus.Eng_Start) begin
        e_a    = bus.Eng_Ain;
        e_b    = bus.Eng_Bin;
        e_busy = 1'b1;
        e_cnt  = (eng_lat_fix > 0) ? eng_lat_fix : int'($urandom_range(1, 6));
      end else if (e_busy && !bus.Eng_Done) begin
        if (e_cnt <= 1) begin
          bus.Eng_Done   = 1'b1;
          bus.Eng_Result = ref_gcd(e_a, e_b);
        end else begin
          e_cnt--;
          bus.Eng_Result = W'($urandom);
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [N_REQ-1:0] m_gnt_prev, m_valid_prev, m_ack_prev, m_req_prev;
  logic             m_engack_prev;
  int               m_ref_ptr, m_idx, m_nstart, m_nack, m_expi;
  logic [W-1:0]     m_hold, m_e;
  bit               m_nz;

  initial begin
    m_ref_ptr = 0; m_idx = 0; m_nstart = 0; m_nack = 0;
    m_gnt_prev = '0; m_valid_prev = '0; m_ack_prev = '0; m_req_prev = '0;
    m_engack_prev = 1'b0; m_hold = '0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        m_ref_ptr = 0; m_nstart = 0; m_nack = 0;
        m_gnt_prev = '0; m_valid_prev = '0; m_ack_prev = '0; m_req_prev = '0;
        m_engack_prev = 1'b0;
      end else begin
        chk("status", 32'({bus.Busy, bus.q_Idle,
                           ($countones({bus.q_Idle, bus.q_Load, bus.q_Run, bus.q_Ack, bus.q_Resp}) == 1)}),
                      32'({(bus.Grant != '0), (bus.Grant == '0), 1'b1}));

        if (m_gnt_prev == '0 && bus.Grant != '0) begin
          m_nstart = 0;
          m_nack   = 0;
          m_expi   = rr_pick(m_req_prev, m_ref_ptr);
          chk("grant", 32'(bus.Grant), (m_expi < 0) ? 0 : (32'(1) << m_expi));
          if (m_expi >= 0) begin
            m_idx     = m_expi;
            m_ref_ptr = (m_expi + 1) % int'(N_REQ);
            chk("eng_ops", 32'({bus.Eng_Ain, bus.Eng_Bin}), 32'({cur_a[m_idx], cur_b[m_idx]}));
            m_nz = (cur_a[m_idx] != '0) && (cur_b[m_idx] != '0);
            chk("bypass_latency", 32'(bus.Rsp_Valid), m_nz ? 0 : 32'(bus.Grant));
          end
        end else if (m_gnt_prev != '0 && bus.Grant != '0) begin
          chk("grant_hold", 32'(bus.Grant), 32'(m_gnt_prev));
        end else if (m_gnt_prev != '0 && bus.Grant == '0) begin
          chk("release_on_ack", 32'((m_valid_prev & m_ack_prev & m_gnt_prev) != '0), 1);
        end

        if (bus.Eng_Start) begin
          m_nstart++;
          chk("start_ops", 32'({bus.Eng_Ain, bus.Eng_Bin}), 32'({cur_a[m_idx], cur_b[m_idx]}));
        end
        if (bus.Eng_Ack) m_nack++;

        if (bus.Rsp_Valid != '0 && m_valid_prev == '0) begin
          chk("valid_is_grant", 32'(bus.Rsp_Valid), 32'(bus.Grant));
          m_nz = (cur_a[m_idx] != '0) && (cur_b[m_idx] != '0);
          if (exp_q[m_idx].size() == 0) begin
            chk("unexpected_rsp", 1, 0);
          end else begin
            m_e = exp_q[m_idx].pop_front();
            chk("rsp_data", 32'(bus.Rsp_Data), 32'(m_e));
            m_hold = m_e;
          end
          chk("start_count", m_nstart, m_nz ? 1 : 0);
          chk("eng_ack_count", m_nack, m_nz ? 1 : 0);
          if (m_nz) chk("ack_to_valid", 32'(m_engack_prev), 1);
        end else if (bus.Rsp_Valid != '0) begin
          chk("valid_hold", 32'(bus.Rsp_Valid), 32'(m_valid_prev));
          chk("data_hold", 32'(bus.Rsp_Data), 32'(m_hold));
        end else if (m_valid_prev != '0 && bus.Grant != '0) begin
          chk("valid_drop", 32'(bus.Rsp_Valid), 32'(m_valid_prev));
        end

        m_gnt_prev    = bus.Grant;
        m_valid_prev  = bus.Rsp_Valid;
        m_ack_prev    = bus.Rsp_Ack;
        m_req_prev    = bus.Req;
        m_engack_prev = bus.Eng_Ack;
      end
    end
  end

  // ---------------- requester stimulus ----------------
  task automatic add_tx(input int i, input int unsigned a, input int unsigned b,
                        input int unsigned gap, input int unsigned ackd);
    tx_t t;
    t.a = a; t.b = b; t.gap = gap; t.ackd = ackd;
    tx_q[i].push_back(t);
  endtask

  task automatic present(input int i, input tx_t t);
    bus.Req[i]           = 1'b1;
    bus.ReqA[i*W +: W]   = W'(t.a);
    bus.ReqB[i*W +: W]   = W'(t.b);
    cur_a[i]             = W'(t.a);
    cur_b[i]             = W'(t.b);
    exp_q[i].push_back(ref_gcd(W'(t.a), W'(t.b)));
    ackc[i]              = int'(t.ackd);
    st[i]                = 1;
  endtask

  task automatic step();
    tx_t t;
    for (int i = 0; i < int'(N_REQ); i++) begin
      case (st[i])
        0: begin
          if (tx_q[i].size() != 0) begin
            t = tx_q[i][0];
            if (t.gap > 0) begin
              t.gap--;
              tx_q[i][0] = t;
            end else begin
              present(i, tx_q[i].pop_front());
            end
          end
        end
        1: begin
          if (bus.Rsp_Valid[i]) begin
            if (ackc[i] == 0) begin
              bus.Rsp_Ack[i] = 1'b1;
              st[i] = 2;
            end else begin
              ackc[i]--;
            end
          end
        end
        default: begin
          bus.Rsp_Ack[i] = 1'b0;
          if (tx_q[i].size() != 0 && tx_q[i][0].gap == 0) begin
            present(i, tx_q[i].pop_front());
          end else begin
            bus.Req[i] = 1'b0;
            st[i] = 0;
          end
        end
      endcase
    end
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (tx_q[i].size() != 0 || st[i] != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drain(input int budget);
    int cyc;
    cyc = 0;
    while (!all_idle() && cyc < budget) begin
      @(posedge Clk);
      #1;
      step();
      cyc++;
    end
    chk("drain_in_budget", 32'(all_idle()), 1);
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_grant",     32'(bus.Grant), 0);
    chk("rst_rsp_valid", 32'(bus.Rsp_Valid), 0);
    chk("rst_rsp_data",  32'(bus.Rsp_Data), 0);
    chk("rst_eng_ain",   32'(bus.Eng_Ain), 0);
    chk("rst_eng_bin",   32'(bus.Eng_Bin), 0);
    chk("rst_eng_start", 32'(bus.Eng_Start), 0);
    chk("rst_eng_ack",   32'(bus.Eng_Ack), 0);
    chk("rst_busy",      32'(bus.Busy), 0);
    chk("rst_state",     32'({bus.q_Idle, bus.q_Load, bus.q_Run, bus.q_Ack, bus.q_Resp}), 32'(5'b10000));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c;
    int unsigned ra, rb;
    errors = 0;
    checks = 0;
    eng_lat_fix = 0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      st[i] = 0; ackc[i] = 0; cur_a[i] = '0; cur_b[i] = '0;
    end
    Reset       = 1'b1;
    bus.Req     = '0;
    bus.ReqA    = '0;
    bus.ReqB    = '0;
    bus.Rsp_Ack = '0;

    repeat (2) @(posedge Clk);
    #1;
    check_reset_outputs();
    @(negedge Clk);
    Reset = 1'b0;

    // Single request through the engine.
    add_tx(0, 36, 24, 0, 0);
    drain(200);

    // Two simultaneous requesters after the pointer moved to 1.
    add_tx(1, 48, 18, 0, 0);
    add_tx(2, 7, 5, 0, 0);
    drain(200);

    // Zero-operand bypass.
    add_tx(0, 0, 17, 0, 0);
    add_tx(0, 0, 0, 0, 0);
    add_tx(3, 45, 0, 0, 0);
    drain(200);

    // Withheld ack while another requester waits.
    add_tx(0, 36, 24, 0, 20);
    add_tx(1, 100, 75, 3, 0);
    drain(300);

    // All requesters holding Req continuously.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        add_tx(i, $urandom_range(1, 255), $urandom_range(1, 255), 0, 0);
      end
    end
    drain(1000);

    // Randomized traffic with occasional zero operands.
    for (int i = 0; i < int'(N_REQ); i++) begin
      for (int n = 0; n < 12; n++) begin
        ra = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
        rb = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
        add_tx(i, ra, rb, $urandom_range(0, 4), $urandom_range(0, 3));
      end
    end
    drain(6000);

    // Reset while the engine is running.
    eng_lat_fix = 20;
    @(posedge Clk);
    #1;
    cur_a[0]        = 8'd50;
    cur_b[0]        = 8'd30;
    bus.ReqA[0 +: W] = 8'd50;
    bus.ReqB[0 +: W] = 8'd30;
    bus.Req[0]      = 1'b1;
    c = 0;
    while (!bus.q_Run && c < 10) begin
      @(posedge Clk);
      #1;
      c++;
    end
    chk("reached_run", 32'(bus.q_Run), 1);
    bus.Req[0] = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    check_reset_outputs();
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    eng_lat_fix = 0;

    add_tx(0, 100, 75, 0, 0);
    drain(200);

    c = 0;
    for (int i = 0; i < int'(N_REQ); i++) c += exp_q[i].size();
    chk("scoreboard_empty", c, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
